// File: rtl/pixfmt_pkg.sv
// Shared types and helpers for the SD-reader to framebuffer pixel path.
// Source formats, bytes-per-pixel and legal output pixel widths.
package pixfmt_pkg;

    typedef enum logic [1:0] {
        FMT_RGB332 = 2'd0,
        FMT_RGB565 = 2'd1,
        FMT_RGB888 = 2'd2,
        FMT_GRAY8  = 2'd3
    } fmt_e;

    localparam int PIX_W_RGB332 = 8;
    localparam int PIX_W_RGB565 = 16;

    function automatic logic [1:0] bytes_per_pixel(fmt_e f);
        logic [1:0] n;
        unique case (f)
            FMT_RGB565: n = 2'd2;
            FMT_RGB888: n = 2'd3;
            default:    n = 2'd1;
        endcase
        return n;
    endfunction

    function automatic bit pix_w_legal(int w);
        return (w == PIX_W_RGB332) || (w == PIX_W_RGB565);
    endfunction

endpackage

// File: rtl/pixel_stream_formatter_if.sv
// Byte stream in from the SD reader, tagged pixel stream out to the framebuffer.
// master = formatter side, slave = the surrounding source/sink.
interface pixel_stream_formatter_if #(
    parameter int PIX_W = 8
);
    logic [7:0]       sd_data;
    logic             sd_valid;
    logic             sd_ready;
    logic [PIX_W-1:0] pixel_data;
    logic             pixel_valid;
    logic             pixel_ready;
    logic             pixel_sof;
    logic             pixel_eol;
    logic             pixel_eof;
    logic             frame_done;

    modport master (
        input  sd_data, sd_valid, pixel_ready,
        output sd_ready, pixel_data, pixel_valid,
        output pixel_sof, pixel_eol, pixel_eof, frame_done
    );

    modport slave (
        output sd_data, sd_valid, pixel_ready,
        input  sd_ready, pixel_data, pixel_valid,
        input  pixel_sof, pixel_eol, pixel_eof, frame_done
    );
endinterface

// File: rtl/px_color_convert.sv
// Combinational colour conversion: expand source to R8/G8/B8 by MSB
// replication, then truncate to RGB332 or RGB565.
module px_color_convert
    import pixfmt_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  fmt_e             fmt,
    input  logic [23:0]      src,
    output logic [PIX_W-1:0] pix
);
    logic [7:0] r8, g8, b8;

    always_comb begin
        r8 = src[7:0];
        g8 = src[7:0];
        b8 = src[7:0];
        unique case (fmt)
            FMT_RGB332: begin
                r8 = {src[7:5], src[7:5], src[7:6]};
                g8 = {src[4:2], src[4:2], src[4:3]};
                b8 = {4{src[1:0]}};
            end
            FMT_RGB565: begin
                r8 = {src[15:11], src[15:13]};
                g8 = {src[10:5], src[10:9]};
                b8 = {src[4:0], src[4:2]};
            end
            FMT_RGB888: begin
                r8 = src[23:16];
                g8 = src[15:8];
                b8 = src[7:0];
            end
            default: ;
        endcase
    end

    if (PIX_W == PIX_W_RGB565) begin : g_rgb565
        assign pix = {r8[7:3], g8[7:2], b8[7:3]};
    end else begin : g_rgb332
        assign pix = {r8[7:5], g8[7:5], b8[7:6]};
    end

endmodule

// File: rtl/pixel_stream_formatter.sv
// Byte-to-pixel formatter: assembles source pixels, converts them and
// tags frame/line position; one-entry output register with backpressure.
module pixel_stream_formatter
    import pixfmt_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] fmt_sel,
    input  logic       frame_restart,
    pixel_stream_formatter_if.master bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if (!pix_w_legal(PIX_W)) begin : g_bad_pix_w
        $error("pixel_stream_formatter: PIX_W must be 8 or 16");
    end

    logic [1:0]       byte_cnt;
    logic [15:0]      hold;
    fmt_e             fmt_q, fmt_cur;
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [PIX_W-1:0] pix_q, pix_cnv;
    logic             vld_q, sof_q, eol_q, eof_q, done_q;
    logic             accept, first, last, load, x_end, y_end;

    always_comb begin
        first   = (byte_cnt == 2'd0) && (x == '0) && (y == '0);
        fmt_cur = first ? fmt_e'(fmt_sel) : fmt_q;
        accept  = bus.sd_valid && bus.sd_ready;
        last    = byte_cnt == (bytes_per_pixel(fmt_cur) - 2'd1);
        load    = accept && last;
        x_end   = x == XW'(IMG_W - 1);
        y_end   = y == YW'(IMG_H - 1);
    end

    px_color_convert #(.PIX_W(PIX_W)) u_conv (
        .fmt (fmt_cur),
        .src ({hold, bus.sd_data}),
        .pix (pix_cnv)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            hold     <= '0;
            fmt_q    <= FMT_RGB332;
            x        <= '0;
            y        <= '0;
            pix_q    <= '0;
            vld_q    <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (frame_restart) begin
            byte_cnt <= '0;
            x        <= '0;
            y        <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= vld_q && bus.pixel_ready && eof_q;
            if (accept) begin
                byte_cnt <= last ? 2'd0 : byte_cnt + 2'd1;
                if (!last) hold <= {hold[7:0], bus.sd_data};
                if (first) fmt_q <= fmt_cur;
            end
            // a new load always wins over draining the output register
            if (load) begin
                pix_q <= pix_cnv;
                vld_q <= 1'b1;
                sof_q <= (x == '0) && (y == '0);
                eol_q <= x_end;
                eof_q <= x_end && y_end;
                x     <= x_end ? '0 : x + XW'(1);
                if (x_end) y <= y_end ? '0 : y + YW'(1);
            end else if (bus.pixel_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.sd_ready    = !vld_q || bus.pixel_ready;
    assign bus.pixel_data  = pix_q;
    assign bus.pixel_valid = vld_q;
    assign bus.pixel_sof   = sof_q;
    assign bus.pixel_eol   = eol_q;
    assign bus.pixel_eof   = eof_q;
    assign bus.frame_done  = done_q;

endmodule

// File: doc/pixel_stream_formatter.md
Name: pixel_stream_formatter

Overview:
- Parametrised byte-to-pixel formatter between the SD card reader and the framebuffer writer.
- Assembles 1/2/3-byte source pixels (RGB332, RGB565, RGB888, GRAY8), converts them to an 8-bit RGB332 or 16-bit RGB565 framebuffer word, and tags each pixel with frame/line position flags.
- Uses a valid/ready handshake on both sides and applies backpressure to the SD reader.

Parameters:
- PIX_W, 8, output pixel width; legal values 8 (RGB332) and 16 (RGB565).
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- fmt_sel  in  2  source format: 0 RGB332, 1 RGB565 (big-endian), 2 RGB888 (R,G,B byte order), 3 GRAY8
- frame_restart  in  1  synchronous abort/realign pulse
- sd_data  in  8  source byte
- sd_valid  in  1  source byte valid
- sd_ready  out  1  formatter accepts byte
- pixel_data  out  PIX_W  converted pixel
- pixel_valid  out  1  pixel_data valid
- pixel_ready  in  1  framebuffer accepts pixel
- pixel_sof  out  1  pixel is x=0,y=0 (qualified by pixel_valid)
- pixel_eol  out  1  pixel is x=IMG_W-1
- pixel_eof  out  1  pixel is last of frame
- frame_done  out  1  one-cycle pulse when the eof pixel handshakes

Behaviour:
- Reset values:
  - pixel_data=0, pixel_valid=0, all flags 0, frame_done=0.
  - Byte count, x and y all 0.
  - Latched format = RGB332.
- Handshake rules:
  - A byte transfers when sd_valid && sd_ready.
  - A pixel transfers when pixel_valid && pixel_ready.
  - sd_ready = !pixel_valid || pixel_ready (combinational; one-entry output register).
  - pixel_data and flags stay stable while pixel_valid && !pixel_ready.
- Byte assembly:
  - BPP = 1/2/3 per format; byte_cnt counts 0..BPP-1.
  - Non-final bytes go into a 16-bit holding register.
  - On the final byte, the converted pixel loads the output register. pixel_valid rises the next cycle (latency 1 clk from the final byte accepted).
  - If an output handshake and a load coincide, the load wins and pixel_valid stays 1.
- Format latch:
  - fmt_sel is sampled only when byte_cnt=0, x=0 and y=0, on acceptance of the first byte of a frame.
  - fmt_sel changes mid-frame are ignored until the next frame start.
- Conversion: expand the source to 8-bit R/G/B by MSB replication, then truncate to the output format.
  - Source expansion:
    - RGB332: R8={r3,r3,r3[2:1]}, G8 likewise, B8={b2,b2,b2,b2}.
    - RGB565: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
    - RGB888: bytes used directly.
    - GRAY8: R8=G8=B8=byte.
  - Output truncation:
    - PIX_W=8: {R8[7:5],G8[7:5],B8[7:6]}.
    - PIX_W=16: {R8[7:3],G8[7:2],B8[7:3]}.
  - RGB332 in with PIX_W=8 is an exact passthrough.
- Position counters:
  - x and y advance on each pixel load.
  - x wraps at IMG_W-1 to 0 and increments y.
  - y wraps at IMG_H-1 to 0, which marks the next frame start.
  - Flags are computed from pre-increment x/y and registered with pixel_data.
- frame_done pulses 1 cycle after the eof pixel handshake.
- frame_restart (priority over all else):
  - Next cycle: byte_cnt, x and y are 0; the partial pixel is discarded; pixel_valid=0.
  - A byte presented in the same cycle is accepted and dropped.
  - frame_done is not pulsed.
- Asynchronous reset mid-pixel or mid-frame returns every register to its reset value immediately.
- An illegal PIX_W is a compile-time error (generate-time assertion).

Decomposition:
- Shared package pixfmt_pkg:
  - Format enum: FMT_RGB332=0, FMT_RGB565=1, FMT_RGB888=2, FMT_GRAY8=3.
  - bytes_per_pixel function.
  - PIX_W legality constants.
- One sub-module: px_color_convert. Purely combinational. Inputs: fmt, 24-bit assembled bytes. Output: PIX_W pixel. Parametrised by PIX_W.
- Top level keeps the handshake, byte counter, x/y counters and flags.

Test Plan:
- PIX_W=8, fmt=0, bytes 0xA5,0x3C, pixel_ready=1 -> pixels 0xA5 then 0x3C, each 1 clk after its byte.
- PIX_W=8, fmt=1, bytes 0xF8,0x1F -> single pixel 0xE3; no pixel after the first byte. fmt=3, byte 0x80 -> 0x92.
- PIX_W=16, fmt=2, bytes 0x12,0x34,0x56 -> 0x11AA. PIX_W=8, same bytes -> 0x05.
- IMG_W=4, IMG_H=2, fmt=0, 8 bytes:
  - sof on pixel 0 only.
  - eol on pixels 3 and 7.
  - eof on pixel 7.
  - frame_done 1 clk after pixel 7 handshakes.
  - Then the counters restart at 0.
- Hold pixel_ready=0 for 5 cycles with sd_valid=1 -> sd_ready=0, pixel_data stable, no byte lost. Release -> order preserved.
- Assert frame_restart after byte 1 of an RGB888 pixel -> partial pixel dropped; the next 3 bytes form a pixel with sof=1. fmt_sel changed mid-frame has no effect until the frame wraps.
